mbc1_mapper: RTL

//  MBC1 cartridge bank mapper between dmg_main's CPU bus and the cart storage (cart_prom ROM, optional cart SRAM).

---
 rtl/gb_cart_pkg.sv | 22 ++
 rtl/mbc1_regs.sv | 45 ++++
 rtl/mbc1_mapper.sv | 121 ++++++++++++
 3 files changed

// File: rtl/gb_cart_pkg.sv
// Shared types and constants for the Game Boy cartridge mappers.
// Region bases, open-bus value and the bank-1 zero translation live here.
package gb_cart_pkg;

    typedef enum logic [1:0] {
        SRC_OPEN = 2'd0,
        SRC_ROM  = 2'd1,
        SRC_RAM  = 2'd2
    } cart_src_e;

    localparam logic [15:0] ROM0_BASE  = 16'h0000;
    localparam logic [15:0] ROMX_BASE  = 16'h4000;
    localparam logic [15:0] CRAM_BASE  = 16'hA000;
    localparam logic [7:0]  OPEN_BUS   = 8'hFF;
    localparam logic [3:0]  RAM_EN_KEY = 4'hA;

    // Bank 0 can never be selected in the switchable window; 0 maps to 1.
    function automatic logic [4:0] bank1_fix(input logic [4:0] v);
        return (v == 5'd0) ? 5'd1 : v;
    endfunction

endpackage

// File: rtl/mbc1_regs.sv
// MBC1 control-register file: RAM enable, bank1, bank2 and banking mode.
// Written from CPU stores to 0000-7FFF; i_sel is address bits [14:13].
module mbc1_regs
    import gb_cart_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_wr,
    input  logic [1:0] i_sel,
    input  logic [7:0] i_wdata,
    output logic       o_ram_en,
    output logic [4:0] o_bank1,
    output logic [1:0] o_bank2,
    output logic       o_mode
);

    logic       r_ram_en;
    logic [4:0] r_bank1;
    logic [1:0] r_bank2;
    logic       r_mode;

    // Control register updates from CPU writes into the ROM window
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ram_en <= 1'b0;
            r_bank1  <= 5'h01;
            r_bank2  <= 2'h0;
            r_mode   <= 1'b0;
        end else if (i_wr) begin
            case (i_sel)
                2'd0:    r_ram_en <= (i_wdata[3:0] == RAM_EN_KEY);
                2'd1:    r_bank1  <= bank1_fix(i_wdata[4:0]);
                2'd2:    r_bank2  <= i_wdata[1:0];
                2'd3:    r_mode   <= i_wdata[0];
                default: r_mode   <= r_mode;
            endcase
        end
    end

    assign o_ram_en = r_ram_en;
    assign o_bank1  = r_bank1;
    assign o_bank2  = r_bank2;
    assign o_mode   = r_mode;

endmodule

// File: rtl/mbc1_mapper.sv
// MBC1 bank mapper: decodes CPU writes into control registers, translates
// CPU addresses to banked ROM/SRAM addresses and returns reads one cycle later.
module mbc1_mapper
    import gb_cart_pkg::*;
#(
    parameter  int ROM_AW = 15,
    parameter  int RAM_AW = 13,
    localparam int RAM_PW = (RAM_AW > 0) ? RAM_AW : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       cpu_addr,
    input  logic [7:0]        cpu_wdata,
    input  logic              cpu_wr,
    input  logic              cpu_rd,
    output logic [7:0]        cpu_rdata,
    output logic              cpu_rvalid,
    output logic [ROM_AW-1:0] rom_addr,
    output logic              rom_ce,
    input  logic [7:0]        rom_data,
    output logic [RAM_PW-1:0] ram_addr,
    output logic              ram_ce,
    output logic              ram_we,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_data
);

    localparam logic RAM_PRESENT = (RAM_AW > 0) ? 1'b1 : 1'b0;

    logic        w_ram_en;
    logic [4:0]  w_bank1;
    logic [1:0]  w_bank2;
    logic        w_mode;
    logic        w_rd_acc;
    logic        w_in_rom;
    logic        w_in_cram;
    logic        w_ram_live;
    logic [1:0]  w_hi_bank;
    logic [20:0] w_rom_full;
    logic [14:0] w_ram_full;
    cart_src_e   w_src;
    cart_src_e   r_src;
    logic        r_rvalid;
    logic        w_unused;

    assign w_in_rom  = (cpu_addr[15:14] == ROM0_BASE[15:14]) ||
                       (cpu_addr[15:14] == ROMX_BASE[15:14]);
    assign w_in_cram = (cpu_addr[15:13] == CRAM_BASE[15:13]);

    mbc1_regs u_regs (
        .clk      (clk),
        .rst      (rst),
        .i_wr     (cpu_wr & w_in_rom),
        .i_sel    (cpu_addr[14:13]),
        .i_wdata  (cpu_wdata),
        .o_ram_en (w_ram_en),
        .o_bank1  (w_bank1),
        .o_bank2  (w_bank2),
        .o_mode   (w_mode)
    );

    // A simultaneous write takes the bus; the read is dropped entirely.
    assign w_rd_acc   = cpu_rd & ~cpu_wr;
    assign w_ram_live = w_ram_en & RAM_PRESENT;
    assign w_hi_bank  = w_mode ? w_bank2 : 2'b00;

    // Full 21-bit ROM address before truncation to the cart size
    always_comb begin
        w_rom_full = 21'd0;
        if (cpu_addr[14] == ROMX_BASE[14]) begin
            w_rom_full = {w_bank2, w_bank1, cpu_addr[13:0]};
        end else begin
            w_rom_full = {w_hi_bank, 5'b00000, cpu_addr[13:0]};
        end
    end

    assign w_ram_full = {w_hi_bank, cpu_addr[12:0]};
    assign rom_addr   = w_rom_full[ROM_AW-1:0];
    assign ram_addr   = w_ram_full[RAM_PW-1:0];
    assign ram_wdata  = cpu_wdata;

    assign rom_ce = ~rst & w_rd_acc & w_in_rom;
    assign ram_ce = ~rst & (cpu_rd | cpu_wr) & w_in_cram & w_ram_live;
    assign ram_we = ~rst & cpu_wr & w_in_cram & w_ram_live;

    // Source of the byte that will be returned next cycle
    always_comb begin
        w_src = SRC_OPEN;
        if (w_in_rom) begin
            w_src = SRC_ROM;
        end else if (w_in_cram && w_ram_live) begin
            w_src = SRC_RAM;
        end else begin
            w_src = SRC_OPEN;
        end
    end

    // Read pipeline: tag and valid for the read accepted this cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rvalid <= 1'b0;
            r_src    <= SRC_OPEN;
        end else begin
            r_rvalid <= w_rd_acc;
            r_src    <= w_rd_acc ? w_src : SRC_OPEN;
        end
    end

    // Return mux; idle tag is OPEN so the bus rests at 0xFF
    always_comb begin
        case (r_src)
            SRC_ROM: cpu_rdata = rom_data;
            SRC_RAM: cpu_rdata = ram_data;
            default: cpu_rdata = OPEN_BUS;
        endcase
    end

    assign cpu_rvalid = r_rvalid;
    assign w_unused   = ^{w_rom_full, w_ram_full, ram_data};

endmodule
